// File: rtl/key_debounce_pkg.sv
// Shared constants and state encoding for the key debounce block.
// Debounce lengths are in clk cycles at 20 MHz.
package key_debounce_pkg;

    localparam int KEY_DEBOUNCE_CYC_10MS = 200000;
    localparam int KEY_DEBOUNCE_CYC_SIM  = 8;

    typedef enum logic {
        STABLE = 1'b0,
        CHECK  = 1'b1
    } deb_state_e;

endpackage

// File: rtl/key_debounce_ch.sv
// One debounce channel: two-flop synchroniser, stability counter, FSM,
// and registered level/rise/fall/toggle outputs.
//
// state  | meaning
// STABLE | sync2 matches committed level, counter idle at 0
// CHECK  | sync2 differs from level, counting consecutive mismatching cycles
module key_debounce_ch
    import key_debounce_pkg::*;
#(
    parameter int DEBOUNCE_CYC = KEY_DEBOUNCE_CYC_10MS,
    parameter int CNT_W        = 18
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key,
    output logic level,
    output logic rise,
    output logic fall,
    output logic tog
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic             sync1, sync2;
    deb_state_e       state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             level_nxt, rise_nxt, fall_nxt, tog_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= key;
            sync2 <= sync1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= STABLE;
            cnt   <= '0;
            level <= 1'b0;
            rise  <= 1'b0;
            fall  <= 1'b0;
            tog   <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            level <= level_nxt;
            rise  <= rise_nxt;
            fall  <= fall_nxt;
            tog   <= tog_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        level_nxt = level;
        rise_nxt  = 1'b0;
        fall_nxt  = 1'b0;
        tog_nxt   = tog;
        case (state)
            STABLE: begin
                cnt_nxt = '0;
                if (sync2 != level) begin
                    state_nxt = CHECK;
                    cnt_nxt   = CNT_ONE;
                end
            end
            CHECK: begin
                if (sync2 == level) begin
                    state_nxt = STABLE;
                    cnt_nxt   = '0;
                end else if (cnt == CNT_LAST) begin
                    // counter stops here, so it can never wrap
                    state_nxt = STABLE;
                    cnt_nxt   = '0;
                    level_nxt = sync2;
                    rise_nxt  = sync2;
                    fall_nxt  = ~sync2;
                    if (sync2) tog_nxt = ~tog;
                end else begin
                    cnt_nxt = cnt + CNT_ONE;
                end
            end
            default: begin
                state_nxt = STABLE;
                cnt_nxt   = '0;
            end
        endcase
    end

endmodule

// File: rtl/key_debounce.sv
// Debounce for CH_NUM raw board switches/buttons; each channel is
// fully independent and synchronised to clk.
module key_debounce
    import key_debounce_pkg::*;
#(
    parameter int CH_NUM       = 3,
    parameter int DEBOUNCE_CYC = KEY_DEBOUNCE_CYC_10MS,
    parameter int CNT_W        = 18
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [CH_NUM-1:0] key_i,
    output logic [CH_NUM-1:0] key_level_o,
    output logic [CH_NUM-1:0] key_rise_o,
    output logic [CH_NUM-1:0] key_fall_o,
    output logic [CH_NUM-1:0] key_tog_o
);

    for (genvar g = 0; g < CH_NUM; g++) begin : g_ch
        key_debounce_ch #(
            .DEBOUNCE_CYC(DEBOUNCE_CYC),
            .CNT_W       (CNT_W)
        ) u_ch (
            .clk  (clk),
            .rst_n(rst_n),
            .key  (key_i[g]),
            .level(key_level_o[g]),
            .rise (key_rise_o[g]),
            .fall (key_fall_o[g]),
            .tog  (key_tog_o[g])
        );
    end

endmodule
